// File: rtl/ozphy_pkg.sv
// ozphy_pkg: shared types and constants for the PIPE PHY polling LTSSM model.
// Holds the per-lane LTSSM state encoding and the ordered-set symbol values.
package ozphy_pkg;

    // Per-lane LTSSM state, 4-bit encoding visible on the ltssm_state port.
    typedef enum logic [3:0] {
        DETECT_QUIET   = 4'd0,
        DETECT_ACTIVE  = 4'd1,
        POLLING_ACTIVE = 4'd2,
        POLLING_TS1    = 4'd3,
        POLLING_TS2    = 4'd4,
        POLLING_DONE   = 4'd5
    } ltssm_state_t;

    // Ordered-set symbol values (pre-8b/10b).
    localparam logic [7:0] SYM_COM    = 8'hBC;  // K28.5 comma
    localparam logic [7:0] SYM_PAD    = 8'hF7;  // K23.7 pad
    localparam logic [7:0] TS1_ID     = 8'h4A;  // TS1 identifier (D10.2)
    localparam logic [7:0] TS2_ID     = 8'h45;  // TS2 identifier (D5.2)
    localparam logic [7:0] RATE_ID    = 8'h02;  // 2.5 GT/s only
    localparam logic [7:0] TRAIN_CTRL = 8'h00;  // no training control bits

    // Number of symbols in one TS ordered set.
    localparam int unsigned TS_LEN = 16;

    // PIPE powerdown encodings that matter to this model.
    localparam logic [2:0] PD_P0 = 3'd0;  // fully on, allows leaving DETECT_ACTIVE
    localparam logic [2:0] PD_P2 = 3'd2;  // forces the lane back to DETECT_QUIET

    // rxstatus code reported when a receiver is detected.
    localparam logic [2:0] RXSTATUS_DETECTED = 3'd3;

endpackage

// File: rtl/ozphy_os_gen.sv
// ozphy_os_gen: combinational TS1/TS2 ordered-set symbol generator for one lane.
// Maps (symbol index, TS1/TS2 select, lane index) to an 8-bit symbol and its K flag.
// Config macro OZPHY_TS_LANE_NUM_EN: when defined, symbol 2 carries the lane index
// as a data symbol; otherwise symbol 2 is a PAD K symbol.
module ozphy_os_gen
    import ozphy_pkg::*;
#(
    parameter logic [7:0] N_FTS = 8'h80
) (
    input  logic [3:0] sym,
    input  logic       is_ts2,
    input  logic [7:0] lane_idx,
    output logic [7:0] data,
    output logic       k
);

`ifndef OZPHY_TS_LANE_NUM_EN
    // Lane index only feeds symbol 2 when lane numbering is enabled.
    logic unused_lane_idx;
    assign unused_lane_idx = ^lane_idx;
`endif

    // Symbol lookup: symbols 6..15 are the TS identifier, the rest are fixed fields.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        data = is_ts2 ? TS2_ID : TS1_ID;
        k    = 1'b0;
        case (sym)
            4'd0: begin
                data = SYM_COM;
                k    = 1'b1;
            end
            4'd1: begin
                data = SYM_PAD;
                k    = 1'b1;
            end
            4'd2: begin
`ifdef OZPHY_TS_LANE_NUM_EN
                data = lane_idx;
                k    = 1'b0;
`else
                data = SYM_PAD;
                k    = 1'b1;
`endif
            end
            4'd3: data = N_FTS;
            4'd4: data = RATE_ID;
            4'd5: data = TRAIN_CTRL;
            default: ;
        endcase
    end

endmodule

// File: rtl/ozphy_polling_ltssm.sv
// ozphy_polling_ltssm: N-lane PIPE PHY model running an independent detect/polling
// LTSSM per lane. Each lane detects, settles, sends NTS TS1 sets, NTS2 TS2 sets and
// then reports polling done. All outputs are registered; next-state logic feeds the
// symbol generator so txdata lines up with the state/symbol registers.
// Config macro OZPHY_TS_LANE_NUM_EN (see ozphy_os_gen) selects lane numbering in TS symbol 2.
module ozphy_polling_ltssm
    import ozphy_pkg::*;
#(
    parameter int          N_LANES    = 16,
    parameter int          NTS        = 1024,
    parameter int          NTS2       = 16,
    parameter int          SETTLE_CYC = 4,
    parameter logic [7:0]  N_FTS      = 8'h80
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_LANES-1:0]     lane_en,
    input  logic [N_LANES-1:0]     txdetectrx,
    input  logic [3*N_LANES-1:0]   powerdown,
    output logic [3*N_LANES-1:0]   rxstatus,
    output logic [N_LANES-1:0]     phystatus,
    output logic [N_LANES-1:0]     rxelecidle,
    output logic [8*N_LANES-1:0]   txdata,
    output logic [N_LANES-1:0]     txdatak,
    output logic [N_LANES-1:0]     txvalid,
    output logic [4*N_LANES-1:0]   ltssm_state,
    output logic [N_LANES-1:0]     polling_done
);

    // State constants in plain logic form, values taken from the package enum.
    localparam logic [3:0] ST_DETECT_QUIET   = DETECT_QUIET;
    localparam logic [3:0] ST_DETECT_ACTIVE  = DETECT_ACTIVE;
    localparam logic [3:0] ST_POLLING_ACTIVE = POLLING_ACTIVE;
    localparam logic [3:0] ST_POLLING_TS1    = POLLING_TS1;
    localparam logic [3:0] ST_POLLING_TS2    = POLLING_TS2;
    localparam logic [3:0] ST_POLLING_DONE   = POLLING_DONE;

    // The set counter is shared by TS1 and TS2, so size it for the larger of the two.
    localparam int TS_MAX = (NTS > NTS2) ? NTS : NTS2;
    localparam int TS_W   = $clog2(TS_MAX + 1);
    localparam int ST_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

    localparam logic [TS_W-1:0] TS1_LAST    = TS_W'(NTS - 1);
    localparam logic [TS_W-1:0] TS2_LAST    = TS_W'(NTS2 - 1);
    localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYC - 1);

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane

        localparam logic [7:0] LANE_IDX = 8'(l);

        logic [3:0]      state_q,    state_d;
        logic [3:0]      sym_q,      sym_d;
        logic [TS_W-1:0] ts_cnt_q,   ts_cnt_d;
        logic [ST_W-1:0] settle_q,   settle_d;
        logic [2:0]      rxstatus_q, rxstatus_d;
        logic            phystatus_q, phystatus_d;
        logic            elecidle_q,  elecidle_d;
        logic [7:0]      txdata_q,   txdata_d;
        logic            txdatak_q,  txdatak_d;
        logic            txvalid_q,  txvalid_d;
        logic            done_q,     done_d;

        logic [2:0]      pd;
        logic            abort;
        logic            ts_last_sym;
        logic            ts_last_set;
        logic [7:0]      gen_data;
        logic            gen_k;

        assign pd = powerdown[3*l +: 3];

        // Any state except DETECT_QUIET falls back on lane disable or P2.
        assign abort = (state_q != ST_DETECT_QUIET) && (!lane_en[l] || (pd == PD_P2));

        assign ts_last_sym = (sym_q == 4'(TS_LEN - 1));
        assign ts_last_set = (state_q == ST_POLLING_TS1) ? (ts_cnt_q == TS1_LAST)
                                                         : (ts_cnt_q == TS2_LAST);

        // Next-state and counter logic; abort overrides every other transition.
        always_comb begin
            state_d     = state_q;
            sym_d       = sym_q;
            ts_cnt_d    = ts_cnt_q;
            settle_d    = settle_q;
            rxstatus_d  = 3'd0;
            phystatus_d = 1'b0;
            elecidle_d  = elecidle_q;

            if (abort) begin
                state_d    = ST_DETECT_QUIET;
                sym_d      = 4'd0;
                ts_cnt_d   = '0;
                settle_d   = '0;
                elecidle_d = 1'b1;
            end else begin
                case (state_q)
                    ST_DETECT_QUIET: begin
                        if (lane_en[l] && txdetectrx[l]) begin
                            state_d     = ST_DETECT_ACTIVE;
                            rxstatus_d  = RXSTATUS_DETECTED;
                            phystatus_d = 1'b1;
                        end
                    end
                    ST_DETECT_ACTIVE: begin
                        // Waiting one cycle after the detect pulse keeps phystatus
                        // from being asserted on back-to-back cycles.
                        if (!phystatus_q && (pd == PD_P0)) begin
                            state_d     = ST_POLLING_ACTIVE;
                            phystatus_d = 1'b1;
                            elecidle_d  = 1'b0;
                            settle_d    = '0;
                        end
                    end
                    ST_POLLING_ACTIVE: begin
                        if (settle_q == SETTLE_LAST) begin
                            state_d  = ST_POLLING_TS1;
                            sym_d    = 4'd0;
                            ts_cnt_d = '0;
                            settle_d = '0;
                        end else begin
                            settle_d = settle_q + 1'b1;
                        end
                    end
                    ST_POLLING_TS1, ST_POLLING_TS2: begin
                        // 4-bit symbol index wraps 15 -> 0 into the next set.
                        sym_d = sym_q + 4'd1;
                        if (ts_last_sym) begin
                            if (ts_last_set) begin
                                ts_cnt_d = '0;
                                state_d  = (state_q == ST_POLLING_TS1) ? ST_POLLING_TS2
                                                                        : ST_POLLING_DONE;
                            end else begin
                                ts_cnt_d = ts_cnt_q + 1'b1;
                            end
                        end
                    end
                    ST_POLLING_DONE: ;
                    default: begin
                        state_d    = ST_DETECT_QUIET;
                        sym_d      = 4'd0;
                        ts_cnt_d   = '0;
                        settle_d   = '0;
                        elecidle_d = 1'b1;
                    end
                endcase
            end
        end

        // Symbol for the upcoming cycle, generated from next-state values.
        ozphy_os_gen #(
            .N_FTS (N_FTS)
        ) u_os_gen (
            .sym      (sym_d),
            .is_ts2   (state_d == ST_POLLING_TS2),
            .lane_idx (LANE_IDX),
            .data     (gen_data),
            .k        (gen_k)
        );

        // Transmit-side outputs are quiet outside the TS states.
        always_comb begin
            txvalid_d = (state_d == ST_POLLING_TS1) || (state_d == ST_POLLING_TS2);
            txdata_d  = txvalid_d ? gen_data : 8'h00;
            txdatak_d = txvalid_d & gen_k;
            done_d    = (state_d == ST_POLLING_DONE);
        end

        // Lane registers with synchronous reset; reset wins over abort and detect.
        always_ff @(posedge clk) begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            if (reset) begin
                state_q     <= ST_DETECT_QUIET;
                sym_q       <= 4'd0;
                ts_cnt_q    <= '0;
                settle_q    <= '0;
                rxstatus_q  <= 3'd0;
                phystatus_q <= 1'b0;
                elecidle_q  <= 1'b1;
                txdata_q    <= 8'h00;
                txdatak_q   <= 1'b0;
                txvalid_q   <= 1'b0;
                done_q      <= 1'b0;
            end else begin
                state_q     <= state_d;
                sym_q       <= sym_d;
                ts_cnt_q    <= ts_cnt_d;
                settle_q    <= settle_d;
                rxstatus_q  <= rxstatus_d;
                phystatus_q <= phystatus_d;
                elecidle_q  <= elecidle_d;
                txdata_q    <= txdata_d;
                txdatak_q   <= txdatak_d;
                txvalid_q   <= txvalid_d;
                done_q      <= done_d;
            end
        end

        assign rxstatus[3*l +: 3]    = rxstatus_q;
        assign phystatus[l]          = phystatus_q;
        assign rxelecidle[l]         = elecidle_q;
        assign txdata[8*l +: 8]      = txdata_q;
        assign txdatak[l]            = txdatak_q;
        assign txvalid[l]            = txvalid_q;
        assign ltssm_state[4*l +: 4] = state_q;
        assign polling_done[l]       = done_q;

    end : g_lane

endmodule

// File: tb/tb_ozphy_polling_ltssm.sv
// tb_ozphy_polling_ltssm: directed bench for the polling LTSSM with NTS=4, NTS2=2,
// SETTLE_CYC=4, 16 lanes. A vector table covers the detect/settle/abort handshake on
// lane 0; hand-written sequences cover the full TS walk, restart after abort,
// staggered multi-lane operation, a disabled lane and reset during TS2.
// Honours OZPHY_TS_LANE_NUM_EN when computing the expected TS symbol 2.
module tb_ozphy_polling_ltssm;

    localparam int NL = 16;

    logic            clk;
    logic            reset;
    logic [NL-1:0]   lane_en;
    logic [NL-1:0]   txdetectrx;
    logic [3*NL-1:0] powerdown;
    logic [3*NL-1:0] rxstatus;
    logic [NL-1:0]   phystatus;
    logic [NL-1:0]   rxelecidle;
    logic [8*NL-1:0] txdata;
    logic [NL-1:0]   txdatak;
    logic [NL-1:0]   txvalid;
    logic [4*NL-1:0] ltssm_state;
    logic [NL-1:0]   polling_done;

    int total = 0;
    int bad   = 0;

    ozphy_polling_ltssm #(
        .N_LANES    (NL),
        .NTS        (4),
        .NTS2       (2),
        .SETTLE_CYC (4),
        .N_FTS      (8'h80)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lane_en      (lane_en),
        .txdetectrx   (txdetectrx),
        .powerdown    (powerdown),
        .rxstatus     (rxstatus),
        .phystatus    (phystatus),
        .rxelecidle   (rxelecidle),
        .txdata       (txdata),
        .txdatak      (txdatak),
        .txvalid      (txvalid),
        .ltssm_state  (ltssm_state),
        .polling_done (polling_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference TS symbol model.
    function automatic logic [7:0] exp_data(input int s, input bit ts2, input int lane);
        case (s)
            0: return 8'hBC;
            1: return 8'hF7;
`ifdef OZPHY_TS_LANE_NUM_EN
            2: return 8'(lane);
`else
            2: return 8'hF7;
`endif
            3: return 8'h80;
            4: return 8'h02;
            5: return 8'h00;
            default: return ts2 ? 8'h45 : 8'h4A;
        endcase
    endfunction

    function automatic bit exp_k(input int s);
`ifdef OZPHY_TS_LANE_NUM_EN
        return (s <= 1);
`else
        return (s <= 2);
`endif
    endfunction

    task automatic do_reset();
        reset      = 1'b1;
        lane_en    = '0;
        txdetectrx = '0;
        powerdown  = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rxstatus"},   rxstatus,      '0);
        check({tag, "_phystatus"},  phystatus,     '0);
        check({tag, "_rxelecidle"}, rxelecidle,    {NL{1'b1}});
        check({tag, "_txdata_any"}, |txdata,       0);
        check({tag, "_txdatak"},    txdatak,       '0);
        check({tag, "_txvalid"},    txvalid,       '0);
        check({tag, "_state"},      ltssm_state,   '0);
        check({tag, "_done"},       polling_done,  '0);
    endtask

    // Detect lane 0 and walk it through POLLING_ACTIVE; returns at first TS1 cycle.
    task automatic run_to_ts1();
        int n;
        int pa;
        lane_en[0]       = 1'b1;
        txdetectrx[0]    = 1'b1;
        powerdown[2:0]   = 3'd0;
        step();
        txdetectrx[0] = 1'b0;
        n = 0;
        while (ltssm_state[3:0] != 4'd2 && n < 10) begin
            step();
            n++;
        end
        check("reach_polling_active", ltssm_state[3:0], 4'd2);
        pa = 0;
        while (ltssm_state[3:0] == 4'd2 && pa < 20) begin
            check("pa_rxelecidle", rxelecidle[0], 1'b0);
            step();
            pa++;
        end
        check("settle_cycles", pa, 4);
    endtask

    // Compare n_sym consecutive TS symbols on lane 0, starting at symbol 0.
    task automatic walk_ts(input bit ts2, input int n_sym);
        for (int i = 0; i < n_sym; i++) begin
            check(ts2 ? "ts2_state" : "ts1_state", ltssm_state[3:0], ts2 ? 4'd4 : 4'd3);
            check("ts_data",  txdata[7:0], exp_data(i % 16, ts2, 0));
            check("ts_k",     txdatak[0],  exp_k(i % 16));
            check("ts_valid", txvalid[0],  1'b1);
            step();
        end
    endtask

    typedef struct packed {
        bit         en;
        bit         det;
        logic [2:0] pd;
        logic [3:0] st;
        logic [2:0] rxs;
        bit         phy;
        bit         eidle;
        bit         tv;
    } vec_t;

    vec_t vecs [16];

    int ts1_at  [NL];
    int done_at [NL];
    int errs    [NL];

    initial begin
        // Lane 0 handshake vectors: inputs applied before an edge, outputs after it.
        vecs[0]  = '{1'b1, 1'b0, 3'd2, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0}; // P2 ignored in quiet
        vecs[1]  = '{1'b0, 1'b1, 3'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0}; // disabled lane
        vecs[2]  = '{1'b1, 1'b1, 3'd2, 4'd1, 3'd3, 1'b1, 1'b1, 1'b0}; // detect
        vecs[3]  = '{1'b1, 1'b0, 3'd3, 4'd1, 3'd0, 1'b0, 1'b1, 1'b0}; // status clears
        vecs[4]  = '{1'b1, 1'b0, 3'd3, 4'd1, 3'd0, 1'b0, 1'b1, 1'b0}; // wait for P0
        vecs[5]  = '{1'b1, 1'b0, 3'd0, 4'd2, 3'd0, 1'b1, 1'b0, 1'b0}; // enter polling
        vecs[6]  = '{1'b1, 1'b0, 3'd0, 4'd2, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'd0, 4'd2, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 3'd0, 4'd2, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 3'd0, 4'd3, 3'd0, 1'b0, 1'b0, 1'b1}; // first TS1
        vecs[10] = '{1'b1, 1'b0, 3'd1, 4'd3, 3'd0, 1'b0, 1'b0, 1'b1}; // P1 ignored
        vecs[11] = '{1'b1, 1'b0, 3'd2, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0}; // P2 abort
        vecs[12] = '{1'b1, 1'b1, 3'd0, 4'd1, 3'd3, 1'b1, 1'b1, 1'b0}; // re-detect
        vecs[13] = '{1'b1, 1'b1, 3'd0, 4'd1, 3'd0, 1'b0, 1'b1, 1'b0}; // no double pulse
        vecs[14] = '{1'b0, 1'b0, 3'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0}; // disable abort
        vecs[15] = '{1'b1, 1'b0, 3'd0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0}; // idle quiet

        // Reset with every lane requesting detect: reset must win.
        reset      = 1'b1;
        lane_en    = '1;
        txdetectrx = '1;
        powerdown  = '0;
        step();
        step();
        check_reset_outputs("reset_init");
        do_reset();

        // Table-driven handshake on lane 0.
        for (int i = 0; i < 16; i++) begin
            lane_en        = {{(NL-1){1'b0}}, vecs[i].en};
            txdetectrx     = {{(NL-1){1'b0}}, vecs[i].det};
            powerdown[2:0] = vecs[i].pd;
            step();
            check($sformatf("vec%0d_state", i),    ltssm_state[3:0], vecs[i].st);
            check($sformatf("vec%0d_rxstatus", i), rxstatus[2:0],    vecs[i].rxs);
            check($sformatf("vec%0d_phystatus", i), phystatus[0],    vecs[i].phy);
            check($sformatf("vec%0d_elecidle", i), rxelecidle[0],    vecs[i].eidle);
            check($sformatf("vec%0d_txvalid", i),  txvalid[0],       vecs[i].tv);
        end

        // Abort at TS1 set 1 symbol 7, then a full clean run from scratch.
        do_reset();
        run_to_ts1();
        walk_ts(1'b0, 23);
        check("abort_pre_data", txdata[7:0], 8'h4A);
        powerdown[2:0] = 3'd2;
        step();
        check("abort_state",    ltssm_state[3:0], 4'd0);
        check("abort_elecidle", rxelecidle[0],    1'b1);
        check("abort_txvalid",  txvalid[0],       1'b0);
        check("abort_txdata",   txdata[7:0],      8'h00);
        powerdown[2:0] = 3'd0;
        run_to_ts1();
        walk_ts(1'b0, 64);
        walk_ts(1'b1, 32);
        check("done_state",    ltssm_state[3:0], 4'd5);
        check("done_flag",     polling_done[0],  1'b1);
        check("done_txvalid",  txvalid[0],       1'b0);
        check("done_txdata",   txdata[7:0],      8'h00);
        check("done_txdatak",  txdatak[0],       1'b0);
        check("done_elecidle", rxelecidle[0],    1'b0);
        step();
        check("done_hold", ltssm_state[3:0], 4'd5);

        // Lane 3 disabled while requesting detect.
        do_reset();
        lane_en       = 16'hFFF7;
        txdetectrx[3] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            check("lane3_state", ltssm_state[15:12], 4'd0);
            check("lane3_phy",   phystatus[3],       1'b0);
        end

        // All lanes, detect staggered by one cycle per lane.
        do_reset();
        lane_en = '1;
        for (int l = 0; l < NL; l++) begin
            ts1_at[l]  = -1;
            done_at[l] = -1;
            errs[l]    = 0;
        end
        for (int c = 0; c < 140; c++) begin
            txdetectrx = (c < NL) ? (NL'(1) << c) : '0;
            step();
            for (int l = 0; l < NL; l++) begin
                logic [3:0] s;
                s = ltssm_state[4*l +: 4];
                if (s == 4'd3 && ts1_at[l] < 0) ts1_at[l] = c;
                if (polling_done[l] && done_at[l] < 0) done_at[l] = c;
                if ((s == 4'd3 || s == 4'd4) && ts1_at[l] >= 0) begin
                    int  pos;
                    bit  ts2;
                    pos = c - ts1_at[l];
                    ts2 = (pos >= 64);
                    if (s != (ts2 ? 4'd4 : 4'd3)) errs[l]++;
                    if (txdata[8*l +: 8] !== exp_data(pos % 16, ts2, l)) errs[l]++;
                    if (txdatak[l] !== exp_k(pos % 16)) errs[l]++;
                    if (txvalid[l] !== 1'b1) errs[l]++;
                end
            end
        end
        for (int l = 0; l < NL; l++) begin
            check($sformatf("lane%0d_ts1_cycle", l),  ts1_at[l],  l + 6);
            check($sformatf("lane%0d_done_cycle", l), done_at[l], l + 102);
            check($sformatf("lane%0d_sym_errs", l),   errs[l],    0);
        end

        // Reset in the middle of TS2.
        do_reset();
        run_to_ts1();
        walk_ts(1'b0, 64);
        walk_ts(1'b1, 5);
        check("pre_reset_state", ltssm_state[3:0], 4'd4);
        reset          = 1'b1;
        lane_en        = '1;
        txdetectrx     = '1;
        powerdown[2:0] = 3'd2;
        step();
        check_reset_outputs("reset_ts2");
        reset      = 1'b0;
        txdetectrx = '0;
        lane_en    = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
